// File: rtl/wam_game.sv
// Whack-a-mole engine: one pseudo-random mole at a time, difficulty-dependent lifetime,
// edge-detected taps and a saturating 3-digit BCD score.
module wam_game #(
  parameter int          LIFE_EASY  = 150,
  parameter int          LIFE_MED   = 100,
  parameter int          LIFE_HARD  = 50,
  parameter int          COOL_TICKS = 20,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        tick,
  input  logic        pse,
  input  logic [1:0]  hrdn,
  input  logic [7:0]  tap,
  output logic [7:0]  holes,
  output logic [11:0] score,
  output logic        hit,
  output logic        miss
);

  typedef enum logic [1:0] {COOL, SPAWN, UP} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [7:0]  tap_q;
  logic [7:0]  tap_rise;
  logic [7:0]  cool_cnt;
  logic [7:0]  life_cnt;
  logic [7:0]  life_sel;
  logic [2:0]  prev_idx;
  logic [2:0]  spawn_idx;
  logic [11:0] score_inc;
  logic        fb;

  assign tap_rise  = tap & ~tap_q;
  assign fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  // Never raise the same hole twice in a row.
  assign spawn_idx = (lfsr[2:0] == prev_idx) ? lfsr[2:0] + 3'd1 : lfsr[2:0];

  always_comb begin
    life_sel = 8'(LIFE_HARD);
    case (hrdn)
      2'd0:    life_sel = 8'(LIFE_EASY);
      2'd1:    life_sel = 8'(LIFE_MED);
      default: life_sel = 8'(LIFE_HARD);
    endcase
  end

  // Per-digit BCD increment, holding at 999.
  always_comb begin
    score_inc = score;
    if (score != 12'h999) begin
      if (score[3:0] != 4'd9) begin
        score_inc[3:0] = score[3:0] + 4'd1;
      end else begin
        score_inc[3:0] = 4'd0;
        if (score[7:4] != 4'd9) begin
          score_inc[7:4] = score[7:4] + 4'd1;
        end else begin
          score_inc[7:4]  = 4'd0;
          score_inc[11:8] = score[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= COOL;
      lfsr     <= LFSR_SEED;
      tap_q    <= 8'd0;
      cool_cnt <= 8'(COOL_TICKS);
      life_cnt <= 8'd0;
      prev_idx <= 3'd0;
      holes    <= 8'd0;
      score    <= 12'h000;
      hit      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], fb};
      tap_q <= tap;
      hit   <= 1'b0;
      miss  <= 1'b0;
      case (state)
        COOL: begin
          if (tick && !pse) begin
            cool_cnt <= cool_cnt - 8'd1;
            if (cool_cnt == 8'd1) state <= SPAWN;
          end
        end
        SPAWN: begin
          holes    <= 8'd1 << spawn_idx;
          prev_idx <= spawn_idx;
          life_cnt <= life_sel;
          state    <= UP;
        end
        UP: begin
          // A hit takes priority over a timeout landing on the same clock.
          if (!pse && |(tap_rise & holes)) begin
            hit      <= 1'b1;
            score    <= score_inc;
            holes    <= 8'd0;
            cool_cnt <= 8'(COOL_TICKS);
            state    <= COOL;
          end else if (tick && !pse) begin
            if (life_cnt == 8'd1) begin
              miss     <= 1'b1;
              holes    <= 8'd0;
              cool_cnt <= 8'(COOL_TICKS);
              state    <= COOL;
            end else begin
              life_cnt <= life_cnt - 8'd1;
            end
          end
        end
        default: state <= COOL;
      endcase
    end
  end

endmodule

// File: tb/tb_wam_game.sv
// Randomized and directed bench for wam_game with a queue scoreboard fed by a game-level model.
module tb_wam_game;

  logic        clk;
  logic        clr;
  logic        tick;
  logic        pse;
  logic [1:0]  hrdn;
  logic [7:0]  tap;
  logic [7:0]  holes;
  logic [11:0] score;
  logic        hit;
  logic        miss;

  wam_game dut (
    .clk(clk), .clr(clr), .tick(tick), .pse(pse), .hrdn(hrdn), .tap(tap),
    .holes(holes), .score(score), .hit(hit), .miss(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;   // 0 spawn, 1 hit, 2 miss
    logic [7:0]  holes;
    logic [11:0] score;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  passes = 0;
  int  ecount = 0;
  bit  mon_en = 0;
  bit  tgl    = 0;
  logic [7:0] prev_holes = 8'd0;

  // Game-level reference state
  int          m_mole, m_cool, m_life, m_score, m_prev;
  bit          m_spawn;
  logic [15:0] m_lfsr;
  logic [7:0]  m_tapq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [11:0] bcd(input int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic int life_of(input logic [1:0] h);
    return (h == 2'd0) ? 150 : (h == 2'd1) ? 100 : 50;
  endfunction

  task automatic model_reset();
    m_mole = -1; m_cool = 20; m_life = 0; m_score = 0; m_prev = 0;
    m_spawn = 0; m_lfsr = 16'hACE1; m_tapq = 8'd0;
  endtask

  task automatic push(input int k, input logic [7:0] h);
    ev_t e;
    e.cyc = ecount + 1; e.kind = k; e.holes = h; e.score = bcd(m_score);
    sbq.push_back(e);
  endtask

  task automatic model_step();
    logic [7:0] rise;
    int idx;
    rise = tap & ~m_tapq;
    if (m_spawn) begin
      idx = int'(m_lfsr[2:0]);
      if (idx == m_prev) idx = (idx + 1) % 8;
      m_mole = idx; m_prev = idx; m_life = life_of(hrdn); m_spawn = 0;
      push(0, 8'd1 << idx);
    end else if (m_mole >= 0) begin
      if (!pse && rise[m_mole]) begin
        if (m_score < 999) m_score++;
        m_mole = -1; m_cool = 20;
        push(1, 8'd0);
      end else if (tick && !pse) begin
        if (m_life == 1) begin
          m_mole = -1; m_cool = 20;
          push(2, 8'd0);
        end else begin
          m_life--;
        end
      end
    end else if (tick && !pse) begin
      if (m_cool == 1) m_spawn = 1;
      else m_cool--;
    end
    m_tapq = tap;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic step(input logic t, input logic p, input logic [1:0] h, input logic [7:0] tp);
    tick = t; pse = p; hrdn = h; tap = tp;
    model_step();
    @(posedge clk);
    ecount++;
    #1;
  endtask

  task automatic apply_reset();
    mon_en = 0;
    clr = 1'b1; tap = 8'd0; tick = 1'b0; pse = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    model_reset();
    mon_en = 1;
  endtask

  task automatic wait_mole(input logic [1:0] h, input logic [7:0] tp);
    int n;
    n = 0;
    while (m_mole < 0 && n < 400) begin
      step(tgl, 1'b0, h, tp);
      tgl = ~tgl;
      n++;
    end
    if (m_mole < 0) begin
      checks++;
      $display("FAIL wait_mole: no mole after %0d clocks", n);
    end
  endtask

  task automatic ticks_to_miss(input logic [1:0] h, output int n);
    bit got;
    n = 0; got = 0;
    while (!got && n < 400) begin
      step(1'b1, 1'b0, h, 8'd0);
      n++;
      got = miss;
      if (!got) step(1'b0, 1'b0, h, 8'd0);
    end
  endtask

  task automatic do_hit(input logic [1:0] h, output bit got);
    got = 0;
    wait_mole(h, 8'd0);
    if (m_mole >= 0) begin
      step(1'b0, 1'b0, h, 8'd1 << m_mole);
      got = hit;
      step(1'b0, 1'b0, h, 8'd0);
    end
  endtask

  // Monitor: pop the expected event whenever the DUT presents a spawn, hit or miss.
  always @(negedge clk) begin
    int   kind;
    ev_t  e;
    if (mon_en) begin
      while (sbq.size() > 0 && sbq[0].cyc < ecount) begin
        e = sbq.pop_front();
        checks++;
        $display("FAIL missed_event: cycle %0d kind %0d holes %h score %h not presented", e.cyc, e.kind, e.holes, e.score);
      end
      if (hit || miss || (holes != 8'd0 && prev_holes == 8'd0)) begin
        kind = (hit && miss) ? 3 : hit ? 1 : miss ? 2 : 0;
        if (sbq.size() > 0 && sbq[0].cyc == ecount) begin
          e = sbq.pop_front();
          chk("event", {8'd0, 4'(kind), holes, score}, {8'd0, 4'(e.kind), e.holes, e.score});
        end else begin
          checks++;
          $display("FAIL unexpected_event: cycle %0d kind %0d holes %h score %h", ecount, kind, holes, score);
        end
      end
    end
    prev_holes = holes;
  end

  initial begin
    int   n, hits, misses;
    bit   got;
    logic [7:0] saved, rtap;
    logic       rp;
    logic [1:0] rh;

    clr = 1'b1; tick = 1'b0; pse = 1'b0; hrdn = 2'd0; tap = 8'hFF;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_state", {19'd0, holes, score, hit, miss}, 32'd0);
    end
    clr = 1'b0;
    mon_en = 1;

    // First spawn after 20 ticks
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step(1'b0, 1'b0, 2'd0, 8'd0);
      step(1'b1, 1'b0, 2'd0, 8'd0);
    end
    chk("holes_before_spawn", holes, 8'd0);
    step(1'b0, 1'b0, 2'd0, 8'd0);
    chk("first_spawn_onehot", $onehot(holes), 1);
    chk("first_spawn_no_pulse", {hit, miss}, 2'b00);

    // Scored hit, then a held switch across the next spawn
    step(1'b0, 1'b0, 2'd0, 8'hFF);
    chk("hit_pulse", {hit, miss}, 2'b10);
    chk("score_after_hit", score, 12'h001);
    chk("holes_after_hit", holes, 8'd0);
    wait_mole(2'd0, 8'hFF);
    hits = 0;
    repeat (20) begin
      step(tgl, 1'b0, 2'd0, 8'hFF);
      tgl = ~tgl;
      hits += hit;
    end
    chk("held_tap_no_score", hits, 0);
    step(1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, 1'b0, 2'd0, 8'hFF);
    chk("retap_hit", hit, 1);
    chk("retap_score", score, 12'h002);

    // Timeouts per difficulty
    wait_mole(2'd2, 8'd0);
    ticks_to_miss(2'd2, n);
    chk("life_hard", n, 50);
    chk("score_after_miss", score, 12'h002);
    wait_mole(2'd0, 8'd0);
    ticks_to_miss(2'd0, n);
    chk("life_easy", n, 150);

    // Hit and timeout on the same clock
    wait_mole(2'd2, 8'd0);
    n = 0;
    while (m_life > 1 && n < 200) begin
      step(1'b1, 1'b0, 2'd2, 8'd0);
      step(1'b0, 1'b0, 2'd2, 8'd0);
      n++;
    end
    step(1'b1, 1'b0, 2'd2, 8'd1 << m_mole);
    chk("collision_pulses", {hit, miss}, 2'b10);
    chk("collision_score", score, 12'h003);

    // Randomized play
    rtap = 8'd0; rp = 1'b0; rh = 2'd1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) rp = ~rp;
      if ($urandom_range(0, 499) == 0) rh = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) rtap = 8'($urandom);
      if (m_mole >= 0 && $urandom_range(0, 29) == 0) rtap[m_mole] = ~rtap[m_mole];
      step($urandom_range(0, 2) == 0, rp, rh, rtap);
    end

    // Pause freezes the mole lifetime
    apply_reset();
    wait_mole(2'd1, 8'd0);
    repeat (30) begin
      step(1'b1, 1'b0, 2'd1, 8'd0);
      step(1'b0, 1'b0, 2'd1, 8'd0);
    end
    saved = holes; misses = 0;
    repeat (500) begin
      step(1'b1, 1'b1, 2'd1, 8'hFF);
      misses += miss;
      step(1'b0, 1'b1, 2'd1, 8'd0);
      misses += miss;
    end
    chk("pause_holes", holes, saved);
    chk("pause_no_miss", misses, 0);
    ticks_to_miss(2'd1, n);
    chk("pause_resume_life", n, 70);

    // Mid-game asynchronous clear
    apply_reset();
    repeat (42) do_hit(2'd0, got);
    wait_mole(2'd0, 8'd0);
    chk("score_042", score, 12'h042);
    chk("mole_up_before_clr", holes != 8'd0, 1);
    mon_en = 0;
    #2 clr = 1'b1;
    #1;
    chk("async_clr_holes", holes, 8'd0);
    chk("async_clr_score", score, 12'h000);
    apply_reset();

    // BCD carries and saturation
    for (int i = 1; i <= 1001; i++) begin
      do_hit(2'd0, got);
      if (i == 10)  chk("bcd_009_to_010", score, 12'h010);
      if (i == 100) chk("bcd_099_to_100", score, 12'h100);
      if (i == 1001) begin
        chk("sat_hit_pulse", got, 1);
        chk("sat_score", score, 12'h999);
      end
    end

    repeat (3) step(1'b0, 1'b0, 2'd0, 8'd0);
    while (sbq.size() > 0) begin
      ev_t e;
      e = sbq.pop_front();
      checks++;
      $display("FAIL pending_event: kind %0d holes %h score %h never presented", e.kind, e.holes, e.score);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wam_game.md
Name: wam_game

Overview:
- Whack-a-mole game engine that drives the board test harness: it produces the `holes` mole pattern and the 12-bit `score`, and consumes the 8-bit `tap` vector and the 2-bit difficulty.
- It raises one mole at a time in a pseudo-random hole and holds it for a lifetime that depends on difficulty.
- It detects a hit on the tap switch that matches the raised mole and keeps the score as 3-digit BCD for the digit-tube display.

Parameters:
- LIFE_EASY, 150, mole lifetime in ticks when hrdn=0
- LIFE_MED, 100, mole lifetime in ticks when hrdn=1
- LIFE_HARD, 50, mole lifetime in ticks when hrdn=2 or 3
- COOL_TICKS, 20, empty-board ticks between moles
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- clk  input  1  system clock
- clr  input  1  reset, asynchronous, active-high
- tick  input  1  one-clk-wide game-time pulse (~100 Hz)
- pse  input  1  pause level; freezes timers and ignores taps
- hrdn  input  2  difficulty: 0 easy, 1 medium, 2/3 hard
- tap  input  8  switch levels, already synchronized to clk
- holes  output  8  one-hot raised mole, or 0
- score  output  12  BCD {hundreds,tens,ones}
- hit  output  1  one-clk pulse on a scored hit
- miss  output  1  one-clk pulse on mole timeout

Behaviour:
- Reset values (on clr, asynchronous, every register):
  - holes=0, score=12'h000, hit=0, miss=0
  - state=COOL, cool_cnt=COOL_TICKS, life_cnt=0
  - lfsr=LFSR_SEED, tap_q=tap captured as 0, prev_idx=0
- Reset mid-operation clears the raised mole and the score immediately (asynchronous).
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk, regardless of pse, so the spawn hole depends on player timing.
- Tap edges:
  - tap_q <= tap every clk.
  - tap_rise = tap & ~tap_q.
  - Tap edges are evaluated every clk, not only on tick.
- State machine (all registered, one transition per clk max):
  - COOL:
    - On tick with !pse, decrement cool_cnt.
    - When tick && cool_cnt==1, go SPAWN.
  - SPAWN (exactly one clk):
    - idx = lfsr[2:0]; if idx==prev_idx, use idx+1 mod 8.
    - holes <= 1<<idx; prev_idx <= idx.
    - life_cnt <= LIFE selected by hrdn, which is sampled only here.
    - Go UP.
  - UP, hit: if !pse and |(tap_rise & holes), then:
    - hit=1 next clk, score+1
    - holes <= 0, cool_cnt <= COOL_TICKS, go COOL
  - UP, timeout: else if tick && !pse and life_cnt==1, then:
    - miss=1 next clk
    - holes <= 0, cool_cnt <= COOL_TICKS, go COOL
  - UP, otherwise: else if tick && !pse, life_cnt decrements.
- Simultaneous hit and timeout in the same clk: the hit wins; score increments, no miss pulse.
- Taps on non-raised holes, taps in COOL, and taps while pse=1 have no effect and no penalty.
- A held switch does not re-score; only a 0->1 transition counts.
- Pause:
  - pse=1 freezes cool_cnt and life_cnt, and holes stays as is.
  - Releasing pse resumes from the frozen counts.
- Score:
  - BCD increment with per-digit carry at 9->0.
  - Saturates at 12'h999: a hit at 999 still pulses hit, but score stays 999.
- Latency:
  - hit/miss/holes/score update on the clk edge after the triggering condition.
  - holes goes nonzero exactly 1 clk after the COOL->SPAWN tick.
- Lifetime:
  - The raised mole is visible for exactly LIFE ticks absent a hit.
  - Counters are 8-bit; LIFE and COOL parameters must be in 1..255.

Test Plan:
1. Reset and first spawn:
   - Stimulus: assert clr with tap=8'hFF; release; pulse tick 20 times.
   - Required: holes=0 and score=000 throughout reset; holes one-hot 1 clk after the 20th tick; hit=miss=0.
2. Scored hit:
   - Stimulus: with holes=8'h10, raise tap[4].
   - Required: next clk hit=1 for one clk, score=001, holes=0. Holding tap[4] through the next spawn at hole 4 does not score until tap[4] toggles 0->1.
3. Timeout per difficulty:
   - Stimulus: hrdn=2, spawn, no taps.
   - Required: miss pulses on the 50th tick; holes=0 after it; score unchanged.
   - Repeat with hrdn=0: miss on the 150th tick.
4. Hit/timeout collision:
   - Stimulus: assert tap_rise on the raised hole in the same clk as the tick with life_cnt==1.
   - Required: hit=1, miss=0, score increments.
5. BCD carry and saturation:
   - Score 009 + hit -> 010.
   - Score 099 + hit -> 100.
   - Score 999 + hit -> 999 with hit=1.
6. Pause and mid-game reset:
   - pse=1 while UP for 500 ticks -> holes unchanged, no miss; after release, timeout occurs after the remaining life ticks.
   - clr asserted while UP with score=042 -> holes=0 and score=000 immediately, without waiting for a clk edge.
